axi4_master: RTL
================

Name: axi4_master

Overview:
AXI4 initiator that converts a simple command/stream interface into single AXI4 INCR bursts toward the axi4 memory responder. It handles one outstanding transaction at a time, either write (AW, W, B) or read (AR, R). It streams write data in and read data out with zero added latency and reports a completion status per command. It sits between test or DMA logic and the arbiter interface that feeds the memory responder.

Parameters:
DATA_WIDTH, 32, width of WDATA/RDATA and the stream data ports
ADDR_WIDTH, 16, width of AWADDR/ARADDR/cmd_addr

Ports:
ACLK  in  1  clock; all logic on rising edge
ARESET  in  1  synchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_write  in  1  1 = write burst, 0 = read burst
cmd_addr  in  ADDR_WIDTH  burst start address
cmd_len  in  8  beats minus one (AXLEN)
cmd_size  in  3  bytes per beat as log2 (AXSIZE)
wr_valid  in  1  write stream beat valid
wr_ready  out  1  write stream beat taken
wr_data  in  DATA_WIDTH  write stream data
rd_valid  out  1  read stream beat valid
rd_ready  in  1  read stream consumer ready
rd_data  out  DATA_WIDTH  read beat data
rd_last  out  1  final beat of the burst, from the internal count
done_valid  out  1  one-cycle completion pulse
done_resp  out  2  worst response of the burst
done_last_err  out  1  RLAST or WLAST count mismatch seen during the burst
AWADDR/AWLEN/AWSIZE  out  ADDR_WIDTH/8/3  write address channel
AWVALID out 1, AWREADY in 1
WDATA out DATA_WIDTH, WLAST out 1, WVALID out 1, WREADY in 1
BRESP in 2, BVALID in 1, BREADY out 1
ARADDR/ARLEN/ARSIZE  out  ADDR_WIDTH/8/3  read address channel
ARVALID out 1, ARREADY in 1
RDATA in DATA_WIDTH, RRESP in 2, RLAST in 1, RVALID in 1, RREADY out 1

Behaviour:
- Reset values (ARESET sampled high at an edge): state IDLE; all VALID/READY outputs 0; AW*/AR* 0; done_valid 0; done_resp 2'b00; done_last_err 0; beat_cnt 0. If reset is asserted mid-burst, all VALIDs drop at that edge and no done pulse is produced.
- FSM states: IDLE, AW, W, B, AR, R, DONE.
- IDLE:
  - cmd_ready = 1 (combinational on state).
  - On cmd_valid, latch addr, len and size into AW* or AR*; load beat_cnt = cmd_len; clear resp_acc and last_err.
  - Go to AW if cmd_write, else AR.
- AW / AR:
  - AWVALID / ARVALID = 1 from the cycle after acceptance.
  - Address fields are held stable until AWREADY / ARREADY is sampled high, then go to W / R.
  - The VALID deasserts on the edge after the handshake.
- W (combinational passthrough):
  - WVALID = wr_valid; wr_ready = WREADY; WDATA = wr_data; WLAST = (beat_cnt == 0).
  - On each WVALID && WREADY: if beat_cnt == 0, go to B; else beat_cnt -= 1.
  - The burst moves exactly cmd_len + 1 beats.
- B:
  - BREADY = 1.
  - On BVALID, resp_acc = BRESP; go to DONE.
- R (combinational passthrough):
  - rd_valid = RVALID; RREADY = rd_ready; rd_data = RDATA; rd_last = (beat_cnt == 0).
  - On each RVALID && RREADY: resp_acc = max(resp_acc, RRESP) by numeric value; last_err |= (RLAST != (beat_cnt == 0)).
  - If beat_cnt == 0, go to DONE; else decrement.
  - Termination is count-based; RLAST is checked only.
- DONE:
  - done_valid = 1 for exactly one cycle, with done_resp = resp_acc and done_last_err = last_err.
  - Next state IDLE; cmd_ready returns the cycle after DONE.
  - done_resp and done_last_err hold their value until the next DONE.
- Width rules:
  - beat_cnt is 8 bit; cmd_len = 255 gives 256 beats with no wrap issue, because the count stops at 0.
  - Addresses are passed through unmodified. The responder increments addresses and checks 4 KB boundaries.
- Stall handling: wr_valid = 0 or rd_ready = 0 for any number of cycles is allowed. The FSM simply waits. There is no timeout.
- Ordering: AW is completed before any W beat is offered, matching the responder's ordering.
- Minimum latency, len = 0 write with an always-ready responder: accept, AW, W, B, DONE, about 5 cycles.

Decomposition:
- Package axi4_pkg holds:
  - the response localparams (RESP_OKAY 2'b00, RESP_EXOKAY 2'b01, RESP_SLVERR 2'b10, RESP_DECERR 2'b11);
  - the master state enum;
  - the AXLEN/AXSIZE width constants.
- No sub-module: single flat FSM module.

Test Plan:
- Write burst: addr 0x0010, len 3, size 2, data 0xA0..0xA3 → 4 W beats, WLAST on the 4th; BRESP 00 → done_resp 00, done_last_err 0.
- Read the same addresses back: addr 0x0010, len 3 → rd_data 0xA0..0xA3, rd_last on the 4th beat only, done_resp 00.
- Out-of-range write: addr 0x1000 (beyond 1024 words), len 0 → BRESP 10 → done_resp 10.
- Read with a responder that gives RRESP 00, 10, 00 and holds RLAST low on the final beat → done_resp 10, done_last_err 1.
- Backpressure: len 255 write with wr_valid toggling every other cycle, and AWREADY held low for 7 cycles → exactly 256 beats, AWADDR stable while stalled, single done pulse.
- ARESET pulsed during the 2nd beat of a len 3 read → all VALIDs and READYs 0 the next cycle, no done_valid; state is IDLE and cmd_ready = 1 once reset is released.

Source files
------------

// File: rtl/axi4_master_pkg.sv
// Shared constants for the AXI4 initiator: response codes, channel field widths,
// master state encoding and a response-severity helper.
package axi4_pkg;

    localparam int AXLEN_W  = 8;
    localparam int AXSIZE_W = 3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Master state encoding
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_AW   = 3'd1;
    localparam logic [2:0] ST_W    = 3'd2;
    localparam logic [2:0] ST_B    = 3'd3;
    localparam logic [2:0] ST_AR   = 3'd4;
    localparam logic [2:0] ST_R    = 3'd5;
    localparam logic [2:0] ST_DONE = 3'd6;

    // Worst-of by numeric value, so DECERR > SLVERR > EXOKAY > OKAY.
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi4_master.sv
// Single-outstanding AXI4 INCR initiator: turns a command plus write/read stream
// into one AW/W/B or AR/R burst and reports a per-command completion status.
module axi4_master
    import axi4_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [AXLEN_W-1:0]    cmd_len,
    input  logic [AXSIZE_W-1:0]   cmd_size,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  done_valid,
    output logic [1:0]            done_resp,
    output logic                  done_last_err,
    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic [AXLEN_W-1:0]    AWLEN,
    output logic [AXSIZE_W-1:0]   AWSIZE,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic                  WLAST,
    output logic                  WVALID,
    input  logic                  WREADY,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY,
    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic [AXLEN_W-1:0]    ARLEN,
    output logic [AXSIZE_W-1:0]   ARSIZE,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RLAST,
    input  logic                  RVALID,
    output logic                  RREADY
);

    logic [2:0]         state;
    logic [AXLEN_W-1:0] beat_cnt;
    logic [1:0]         resp_acc;
    logic               last_err;
    logic               cnt_zero;
    logic               w_hs;
    logic               r_hs;
    logic [1:0]         r_resp_nxt;
    logic               r_lerr_nxt;

    assign cnt_zero = (beat_cnt == '0);

    // Handshake/valid outputs are pure functions of state, so a reset edge drops them all at once.
    assign cmd_ready  = (state == ST_IDLE) && !ARESET;
    assign AWVALID    = (state == ST_AW);
    assign ARVALID    = (state == ST_AR);
    assign BREADY     = (state == ST_B);
    assign done_valid = (state == ST_DONE);

    assign WVALID   = (state == ST_W) && wr_valid;
    assign wr_ready = (state == ST_W) && WREADY;
    assign WDATA    = wr_data;
    assign WLAST    = (state == ST_W) && cnt_zero;

    assign rd_valid = (state == ST_R) && RVALID;
    assign RREADY   = (state == ST_R) && rd_ready;
    assign rd_data  = RDATA;
    assign rd_last  = (state == ST_R) && cnt_zero;

    assign w_hs       = WVALID && WREADY;
    assign r_hs       = RVALID && RREADY;
    assign r_resp_nxt = resp_max(resp_acc, RRESP);
    assign r_lerr_nxt = last_err | (RLAST != cnt_zero);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state         <= ST_IDLE;
            beat_cnt      <= '0;
            resp_acc      <= RESP_OKAY;
            last_err      <= 1'b0;
            done_resp     <= RESP_OKAY;
            done_last_err <= 1'b0;
            AWADDR        <= '0;
            AWLEN         <= '0;
            AWSIZE        <= '0;
            ARADDR        <= '0;
            ARLEN         <= '0;
            ARSIZE        <= '0;
        end else begin
            case (state)
                ST_IDLE: if (cmd_valid) begin
                    beat_cnt <= cmd_len;
                    resp_acc <= RESP_OKAY;
                    last_err <= 1'b0;
                    if (cmd_write) begin
                        AWADDR <= cmd_addr;
                        AWLEN  <= cmd_len;
                        AWSIZE <= cmd_size;
                        state  <= ST_AW;
                    end else begin
                        ARADDR <= cmd_addr;
                        ARLEN  <= cmd_len;
                        ARSIZE <= cmd_size;
                        state  <= ST_AR;
                    end
                end
                ST_AW: if (AWREADY) state <= ST_W;
                ST_AR: if (ARREADY) state <= ST_R;
                ST_W: if (w_hs) begin
                    if (cnt_zero) state <= ST_B;
                    else          beat_cnt <= beat_cnt - 1'b1;
                end
                ST_B: if (BVALID) begin
                    resp_acc      <= BRESP;
                    done_resp     <= BRESP;
                    done_last_err <= last_err;
                    state         <= ST_DONE;
                end
                // Burst length is governed by the count; RLAST is only cross-checked.
                ST_R: if (r_hs) begin
                    resp_acc <= r_resp_nxt;
                    last_err <= r_lerr_nxt;
                    if (cnt_zero) begin
                        done_resp     <= r_resp_nxt;
                        done_last_err <= r_lerr_nxt;
                        state         <= ST_DONE;
                    end else begin
                        beat_cnt <= beat_cnt - 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
